// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - game FSM, difficulty select, BCD countdown and digit-scan select
// Optional pause input enabled by defining GAME_PAUSE_EN.
module game_timer_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw5,
  input  logic       diff_btn,
  input  logic       start,
  input  logic       catch_evt,
`ifdef GAME_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] gameDifficulty,
  output logic [1:0] gameState,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       count_2
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    ST_FAIL    = 2'd0,
    ST_SUCCESS = 2'd1,
    ST_PLAYING = 2'd2,
    ST_IDLE    = 2'd3
  } state_t;

  state_t        state_q, state_nx;
  logic [1:0]    diff_nx;
  logic [3:0]    tens_nx, ones_nx;
  logic [TW-1:0] sec_cnt, sec_nx;
  logic [SW-1:0] scan_cnt, scan_nx;
  logic          c2_nx;
  logic          diff_q, start_q, catch_q;
  logic          diff_ev, start_ev, catch_ev;
  logic          run;

  assign diff_ev   = diff_btn & ~diff_q;
  assign start_ev  = start & ~start_q;
  assign catch_ev  = catch_evt & ~catch_q;
  assign gameState = state_q;

`ifdef GAME_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  // BCD preset {tens, ones} for each difficulty level
  function automatic logic [7:0] preset(input logic [1:0] d);
    case (d)
      2'd0:    preset = 8'h15;
      2'd1:    preset = 8'h13;
      2'd2:    preset = 8'h09;
      default: preset = 8'h07;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      gameDifficulty <= 2'd0;
      tens           <= 4'd1;
      ones           <= 4'd5;
      sec_cnt        <= '0;
      scan_cnt       <= '0;
      count_2        <= 1'b0;
      diff_q         <= 1'b0;
      start_q        <= 1'b0;
      catch_q        <= 1'b0;
    end else begin
      state_q        <= state_nx;
      gameDifficulty <= diff_nx;
      tens           <= tens_nx;
      ones           <= ones_nx;
      sec_cnt        <= sec_nx;
      scan_cnt       <= scan_nx;
      count_2        <= c2_nx;
      diff_q         <= diff_btn;
      start_q        <= start;
      catch_q        <= catch_evt;
    end
  end

  always_comb begin
    state_nx = state_q;
    diff_nx  = gameDifficulty;
    tens_nx  = tens;
    ones_nx  = ones;
    sec_nx   = sec_cnt;
    scan_nx  = scan_cnt + SW'(1);
    c2_nx    = count_2;

    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_nx = '0;
      c2_nx   = ~count_2;
    end

    case (state_q)
      ST_IDLE: begin
        {tens_nx, ones_nx} = preset(gameDifficulty);
        if (diff_ev && sw5) diff_nx = gameDifficulty + 2'd1;
        if (start_ev && !sw5) begin
          state_nx = ST_PLAYING;
          sec_nx   = '0;
        end
      end
      ST_PLAYING: begin
        // a catch beats a coincident tick, so the timer never moves on that edge
        if (catch_ev) begin
          state_nx = ST_SUCCESS;
        end else if (run) begin
          if (sec_cnt == TW'(TICK_DIV - 1)) begin
            sec_nx = '0;
            if (tens == 4'd0 && ones == 4'd1) begin
              ones_nx  = 4'd0;
              state_nx = ST_FAIL;
            end else if (ones != 4'd0) begin
              ones_nx = ones - 4'd1;
            end else begin
              ones_nx = 4'd9;
              tens_nx = tens - 4'd1;
            end
          end else begin
            sec_nx = sec_cnt + TW'(1);
          end
        end
      end
      default: begin
        if (start_ev) state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
